// File: rtl/hsv_seq_ctrl_pkg.sv
// Shared types and constants for the RGB-to-HSV sequencing controller.
// Values are N-bit sign-magnitude with Q fraction bits.
package hsv_seq_ctrl_pkg;

   localparam int N = 32;
   localparam int Q = 15;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      DIV_H,
      DIV_S,
      MUL_H,
      WRAP,
      OUT
   } state_e;

   typedef enum logic [1:0] {
      BR_R,
      BR_G,
      BR_B
   } branch_e;

   localparam logic [N-1:0] HUE_SCALE = N'(60) << Q;
   localparam logic [N-1:0] HUE_WRAP  = N'(360) << Q;
   localparam logic [N-1:0] OFF_R     = '0;
   localparam logic [N-1:0] OFF_G     = N'(2) << Q;
   localparam logic [N-1:0] OFF_B     = N'(4) << Q;

   function automatic logic [N-1:0] hue_off(input branch_e br);
      logic [N-1:0] o;
      o = OFF_R;
      unique case (br)
         BR_G:    o = OFF_G;
         BR_B:    o = OFF_B;
         default: o = OFF_R;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/hsv_smag_addsub.sv
// Combinational sign-magnitude add/subtract (y = a + b or a - b).
// A zero magnitude always yields a positive sign.
module hsv_smag_addsub
   import hsv_seq_ctrl_pkg::*;
(
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         sub_i,
   output logic [N-1:0] y_o
);

   logic         sa, sb, sgn;
   logic [N-2:0] ma, mb, mag;

   always_comb begin
      sa  = a_i[N-1];
      sb  = b_i[N-1] ^ sub_i;
      ma  = a_i[N-2:0];
      mb  = b_i[N-2:0];
      mag = '0;
      sgn = 1'b0;
      if (sa == sb) begin
         mag = ma + mb;
         sgn = sa;
      end else if (ma >= mb) begin
         mag = ma - mb;
         sgn = sa;
      end else begin
         mag = mb - ma;
         sgn = sb;
      end
      if (mag == '0) sgn = 1'b0;
      y_o = {sgn, mag};
   end

endmodule

// File: rtl/hsv_seq_ctrl.sv
// Sequences one pixel through the shared divider and multiplier
// to produce H, S and V in sign-magnitude Q format.
module hsv_seq_ctrl
   import hsv_seq_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   r,
   input  logic [7:0]   g,
   input  logic [7:0]   b,
   output logic         div_start,
   output logic [N-1:0] div_dividend,
   output logic [N-1:0] div_divisor,
   input  logic         div_complete,
   input  logic [N-1:0] div_quotient,
   input  logic         div_overflow,
   output logic         mul_start,
   output logic [N-1:0] mul_a,
   output logic [N-1:0] mul_b,
   input  logic         mul_complete,
   input  logic [N-1:0] mul_result,
   input  logic         mul_overflow,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] h,
   output logic [N-1:0] s,
   output logic [N-1:0] v,
   output logic         err
);

   state_e       state_q, state_d;
   branch_e      br_q, br_d, br;
   logic [N-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic [N-1:0] delta_q, delta_d, num_q, num_d;
   logic [N-1:0] v_q, v_d, s_q, s_d, h_q, h_d;
   logic [N-1:0] frac_q, frac_d, mres_q, mres_d;
   logic         nsign_q, nsign_d, err_q, err_d;
   logic         busy_q, busy_d;

   logic [N-1:0] cmax, cmin, na, nb;
   logic [N-1:0] delta, num, mula, wrapped;
   logic         accept, div_done, mul_done, in_div;

   always_comb begin
      br = BR_B;
      if (r_q >= g_q && r_q >= b_q) br = BR_R;
      else if (g_q >= b_q) br = BR_G;
   end

   always_comb begin
      cmax = b_q;
      na   = r_q;
      nb   = g_q;
      unique case (br)
         BR_R: begin
            cmax = r_q;
            na   = g_q;
            nb   = b_q;
         end
         BR_G: begin
            cmax = g_q;
            na   = b_q;
            nb   = r_q;
         end
         default: begin
            cmax = b_q;
            na   = r_q;
            nb   = g_q;
         end
      endcase
      cmin = r_q;
      if (g_q < cmin) cmin = g_q;
      if (b_q < cmin) cmin = b_q;
   end

   hsv_smag_addsub u_delta (
      .a_i   (cmax),
      .b_i   (cmin),
      .sub_i (1'b1),
      .y_o   (delta)
   );

   hsv_smag_addsub u_num (
      .a_i   (na),
      .b_i   (nb),
      .sub_i (1'b1),
      .y_o   (num)
   );

   hsv_smag_addsub u_off (
      .a_i   (frac_q),
      .b_i   (hue_off(br_q)),
      .sub_i (1'b0),
      .y_o   (mula)
   );

   // Negative results add a full turn, positive ones subtract it.
   hsv_smag_addsub u_wrap (
      .a_i   (mres_q),
      .b_i   (HUE_WRAP),
      .sub_i (~mres_q[N-1]),
      .y_o   (wrapped)
   );

   assign in_div    = (state_q == DIV_H) || (state_q == DIV_S);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign div_start = in_div && !busy_q;
   assign mul_start = (state_q == MUL_H) && !busy_q;
   assign mul_a     = (state_q == MUL_H) ? mula : '0;
   assign mul_b     = (state_q == MUL_H) ? HUE_SCALE : '0;
   assign accept    = in_valid && in_ready;
   assign div_done  = in_div && busy_q && div_complete;
   assign mul_done  = (state_q == MUL_H) && busy_q && mul_complete;
   assign h         = h_q;
   assign s         = s_q;
   assign v         = v_q;
   assign err       = err_q;

   always_comb begin
      div_dividend = '0;
      div_divisor  = '0;
      if (state_q == DIV_H) begin
         div_dividend = num_q;
         div_divisor  = delta_q;
      end else if (state_q == DIV_S) begin
         div_dividend = delta_q;
         div_divisor  = v_q;
      end
   end

   always_comb begin
      state_d = state_q;
      br_d    = br_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      delta_d = delta_q;
      num_d   = num_q;
      nsign_d = nsign_q;
      v_d     = v_q;
      s_d     = s_q;
      h_d     = h_q;
      frac_d  = frac_q;
      mres_d  = mres_q;
      busy_d  = busy_q;
      err_d   = err_q | (div_done & div_overflow) | (mul_done & mul_overflow);
      if (div_start || mul_start) busy_d = 1'b1;
      if (div_done || mul_done) busy_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               r_d     = {{(N-8-Q){1'b0}}, r, {Q{1'b0}}};
               g_d     = {{(N-8-Q){1'b0}}, g, {Q{1'b0}}};
               b_d     = {{(N-8-Q){1'b0}}, b, {Q{1'b0}}};
               err_d   = 1'b0;
               state_d = PREP;
            end
         end
         PREP: begin
            br_d    = br;
            delta_d = delta;
            num_d   = {1'b0, num[N-2:0]};
            nsign_d = num[N-1];
            v_d     = cmax;
            h_d     = '0;
            s_d     = '0;
            state_d = (delta[N-2:0] == '0) ? OUT : DIV_H;
         end
         DIV_H: begin
            if (div_done) begin
               frac_d  = {nsign_q & (|div_quotient[N-2:0]),
                          div_quotient[N-2:0]};
               state_d = DIV_S;
            end
         end
         DIV_S: begin
            if (div_done) begin
               s_d     = div_quotient;
               state_d = MUL_H;
            end
         end
         MUL_H: begin
            if (mul_done) begin
               mres_d  = mul_result;
               state_d = WRAP;
            end
         end
         WRAP: begin
            if (mres_q[N-1] || ({1'b0, mres_q[N-2:0]} >= HUE_WRAP))
               h_d = wrapped;
            else
               h_d = mres_q;
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         br_q    <= BR_R;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         delta_q <= '0;
         num_q   <= '0;
         nsign_q <= 1'b0;
         v_q     <= '0;
         s_q     <= '0;
         h_q     <= '0;
         frac_q  <= '0;
         mres_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         br_q    <= br_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         delta_q <= delta_d;
         num_q   <= num_d;
         nsign_q <= nsign_d;
         v_q     <= v_d;
         s_q     <= s_d;
         h_q     <= h_d;
         frac_q  <= frac_d;
         mres_q  <= mres_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_hsv_seq_ctrl.sv
// Bench for hsv_seq_ctrl with behavioural divider/multiplier models
// and a queue of expected results built from integer arithmetic.
module tb_hsv_seq_ctrl;
   import hsv_seq_ctrl_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, err;
   logic [7:0]   r, g, b;
   logic         div_start, div_complete, div_overflow;
   logic [N-1:0] div_dividend, div_divisor, div_quotient;
   logic         mul_start, mul_complete, mul_overflow;
   logic [N-1:0] mul_a, mul_b, mul_result;
   logic [N-1:0] h, s, v;

   typedef struct {
      logic [N-1:0] h;
      logic [N-1:0] s;
      logic [N-1:0] v;
      logic         err;
      int           nd;
      int           nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   div_starts = 0;
   int   mul_starts = 0;
   logic inj_dov = 1'b0;

   always #5 clk = ~clk;

   hsv_seq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .r            (r),
      .g            (g),
      .b            (b),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_complete (div_complete),
      .div_quotient (div_quotient),
      .div_overflow (div_overflow),
      .mul_start    (mul_start),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_complete (mul_complete),
      .mul_result   (mul_result),
      .mul_overflow (mul_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .h            (h),
      .s            (s),
      .v            (v),
      .err          (err)
   );

   function automatic logic [N-1:0] div_model(input logic [N-1:0] a,
                                              input logic [N-1:0] d);
      longint unsigned q;
      if (d[N-2:0] == '0) return {1'b0, {(N-1){1'b1}}};
      q = (longint'(a[N-2:0]) << Q) / longint'(d[N-2:0]);
      return {1'b0, q[N-2:0]};
   endfunction

   int           dcnt, mcnt;
   logic [N-1:0] dq_l, mr_l;
   logic         mo_l;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt <= 0;
         div_complete <= 1'b0;
         div_overflow <= 1'b0;
         div_quotient <= '0;
      end else begin
         div_complete <= 1'b0;
         div_overflow <= 1'b0;
         if (div_start) begin
            dcnt <= 4;
            dq_l <= div_model(div_dividend, div_divisor);
         end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
               div_complete <= 1'b1;
               div_quotient <= dq_l;
               div_overflow <= inj_dov;
            end
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mcnt <= 0;
         mul_complete <= 1'b0;
         mul_overflow <= 1'b0;
         mul_result <= '0;
      end else begin
         mul_complete <= 1'b0;
         mul_overflow <= 1'b0;
         if (mul_start) begin
            longint unsigned p;
            logic sg;
            p = (longint'(mul_a[N-2:0]) * longint'(mul_b[N-2:0])) >> Q;
            sg = (mul_a[N-1] ^ mul_b[N-1]) && (p != 0);
            mcnt <= 3;
            mr_l <= {sg, p[N-2:0]};
            mo_l <= (p >> (N-1)) != 0;
         end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
               mul_complete <= 1'b1;
               mul_result <= mr_l;
               mul_overflow <= mo_l;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (div_start) div_starts <= div_starts + 1;
      if (mul_start) mul_starts <= mul_starts + 1;
   end

   function automatic exp_t model_px(input int rr, input int gg,
                                     input int bb, input logic e);
      exp_t   x;
      longint mx, mn, d, num, off, q, mula, hh;
      mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
      mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
      d = mx - mn;
      x.v = N'(mx << Q);
      x.err = e;
      x.nd = (d == 0) ? 0 : 2;
      x.nm = (d == 0) ? 0 : 1;
      x.h = '0;
      x.s = '0;
      if (d != 0) begin
         if (rr >= gg && rr >= bb) begin num = gg - bb; off = 0; end
         else if (gg >= bb) begin num = bb - rr; off = 2; end
         else begin num = rr - gg; off = 4; end
         q = (((num < 0) ? -num : num) << Q) / d;
         if (num < 0) q = -q;
         mula = q + (off << Q);
         hh = mula * 60;
         if (hh < 0) hh = hh + (longint'(360) << Q);
         else if (hh >= (longint'(360) << Q)) hh = hh - (longint'(360) << Q);
         x.h = N'(hh);
         x.s = N'((d << Q) / mx);
      end
      return x;
   endfunction

   task automatic send(input int rr, input int gg, input int bb,
                       input logic e);
      sb.push_back(model_px(rr, gg, bb, e));
      r = 8'(rr);
      g = 8'(gg);
      b = 8'(bb);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 300);
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL timeout out_valid after %0d cycles", lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      r = '0; g = '0; b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, div_start, mul_start, err} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctl got %b want 10000",
                  {in_ready, out_valid, div_start, mul_start, err});
      end
      checks++;
      if ({h, s, v, div_dividend, mul_a, mul_b} !== '0) begin
         errors++;
         $display("FAIL reset_data h=%h s=%h v=%h want 0", h, s, v);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_colors();
      int   px[5][3] = '{'{255,0,0}, '{0,255,0}, '{0,0,255},
                         '{255,255,0}, '{255,0,128}};
      int   lat, d0, m0;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         d0 = div_starts;
         m0 = mul_starts;
         send(px[i][0], px[i][1], px[i][2], 1'b0);
         wait_out(lat);
         e = sb.pop_front();
         checks++;
         if ({h, s, v, err} !== {e.h, e.s, e.v, e.err}) begin
            errors++;
            $display("FAIL color%0d hsv got %h %h %h %b want %h %h %h %b",
                     i, h, s, v, err, e.h, e.s, e.v, e.err);
         end
         checks++;
         if ((div_starts - d0) != e.nd || (mul_starts - m0) != e.nm) begin
            errors++;
            $display("FAIL color%0d starts got %0d/%0d want %0d/%0d",
                     i, div_starts - d0, mul_starts - m0, e.nd, e.nm);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_gray_black();
      int   px[2][3] = '{'{128,128,128}, '{0,0,0}};
      int   lat, d0, m0;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         d0 = div_starts;
         m0 = mul_starts;
         send(px[i][0], px[i][1], px[i][2], 1'b0);
         wait_out(lat);
         e = sb.pop_front();
         checks++;
         if ({h, s, v} !== {e.h, e.s, e.v}) begin
            errors++;
            $display("FAIL flat%0d hsv got %h %h %h want %h %h %h",
                     i, h, s, v, e.h, e.s, e.v);
         end
         checks++;
         if (lat != 2 || div_starts != d0 || mul_starts != m0) begin
            errors++;
            $display("FAIL flat%0d lat/starts got %0d %0d %0d want 2 0 0",
                     i, lat, div_starts - d0, mul_starts - m0);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      int           lat, bad;
      logic [N-1:0] h0, s0, v0;
      exp_t         e;
      out_ready = 1'b0;
      send(255, 255, 0, 1'b0);
      wait_out(lat);
      h0 = h; s0 = s; v0 = v;
      e = sb.pop_front();
      checks++;
      if ({h0, s0, v0} !== {e.h, e.s, e.v}) begin
         errors++;
         $display("FAIL bp_first got %h %h %h want %h %h %h",
                  h0, s0, v0, e.h, e.s, e.v);
      end
      sb.push_back(model_px(0, 0, 255, 1'b0));
      r = 8'd0; g = 8'd0; b = 8'd255;
      in_valid = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if ({out_valid, in_ready, h, s, v} !== {2'b10, h0, s0, v0}) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold unstable cycles got %0d want 0", bad);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL bp_release rdy/vld got %b want 10",
                  {in_ready, out_valid});
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept in_ready got %b want 0", in_ready);
      end
      in_valid = 1'b0;
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if ({h, s, v} !== {e.h, e.s, e.v}) begin
         errors++;
         $display("FAIL bp_second got %h %h %h want %h %h %h",
                  h, s, v, e.h, e.s, e.v);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int   d0, m0, n;
      exp_t e;
      d0 = div_starts;
      send(255, 0, 128, 1'b0);
      n = 0;
      while (div_starts < d0 + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, div_start, mul_start, err} !== 5'b10000 ||
          {h, s, v} !== '0 || n >= 100) begin
         errors++;
         $display("FAIL rst_mid got rdy=%b vld=%b h=%h s=%h v=%h want idle 0",
                  in_ready, out_valid, h, s, v);
      end
      @(negedge clk);
      rst = 1'b0;
      d0 = div_starts;
      m0 = mul_starts;
      repeat (20) @(negedge clk);
      checks++;
      if (div_starts != d0 || mul_starts != m0 || !in_ready || out_valid) begin
         errors++;
         $display("FAIL rst_quiet starts got %0d/%0d want 0/0",
                  div_starts - d0, mul_starts - m0);
      end
   endtask

   task automatic test_overflow();
      int   lat;
      exp_t e;
      inj_dov = 1'b1;
      send(0, 255, 0, 1'b1);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if ({err, h, s} !== {e.err, e.h, e.s}) begin
         errors++;
         $display("FAIL ovf_set err=%b h=%h want err=%b h=%h",
                  err, h, e.err, e.h);
      end
      @(posedge clk);
      #1 inj_dov = 1'b0;
      send(0, 0, 255, 1'b0);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear err got %b want 0", err);
      end
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if ({err, h, s, v} !== {e.err, e.h, e.s, e.v}) begin
         errors++;
         $display("FAIL ovf_next got %b %h want %b %h", err, h, e.err, e.h);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_colors();
      test_gray_black();
      test_backpressure();
      test_reset_mid();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hsv_seq_ctrl.md
Name: hsv_seq_ctrl

Overview:
- Sequencing controller for the RGB-to-HSV conversion path.
- Accepts one 8-bit RGB pixel through a valid/ready handshake and derives cmax, cmin and delta.
- Time-shares one external iterative divider across the hue-fraction and saturation divisions, then drives the external iterative multiplier for the ×60 hue scaling.
- Applies the hue offset, sign correction and 360 wrap, and returns H, S and V through a valid/ready handshake.
- Sits between the pixel source and the shared div/mult units, and replaces free-running start strobes with a proper sequence.

Parameters:
- N, 32, total fixed-point width. Sign-magnitude format: bit N-1 is the sign, bits N-2:Q are the integer part, bits Q-1:0 are the fraction.
- Q, 15, number of fraction bits.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: pixel offered.
- in_ready, output, 1: controller can accept a pixel; high only in IDLE.
- r, g, b, input, 8 each: pixel channels, sampled when in_valid && in_ready.
- div_start, output, 1: one-cycle start pulse to the shared divider.
- div_dividend, output, N: divider operand, positive magnitude.
- div_divisor, output, N: divider operand, positive magnitude.
- div_complete, input, 1: one-cycle done pulse from the divider.
- div_quotient, input, N: divider result, valid in the div_complete cycle.
- div_overflow, input, 1: divider overflow flag, valid in the div_complete cycle.
- mul_start, output, 1: one-cycle start pulse to the multiplier.
- mul_a, output, N: multiplicand, signed.
- mul_b, output, N: multiplier operand, constant 60.0.
- mul_complete, input, 1: one-cycle done pulse from the multiplier.
- mul_result, input, N: multiplier result, valid in the mul_complete cycle.
- mul_overflow, input, 1: multiplier overflow flag.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts the result.
- h, s, v, output, N each: Q-format results.
- err, output, 1: sticky overflow seen during the current pixel.

Behaviour:
- Reset: state = IDLE; all outputs 0 except in_ready = 1. Reset mid-operation aborts the pixel, raises no further start pulses, and leaves no stale result.
- States and transitions:
  - IDLE: on accept, register r/g/b as integer<<Q; go to PREP.
  - PREP, 1 cycle:
    - cmax and cmin computed. Tie priority R > G > B chooses the hue branch:
      - R: numerator G-B, offset 0.
      - G: numerator B-R, offset 2.
      - B: numerator R-G, offset 4.
    - Register delta = cmax-cmin, the numerator magnitude and its sign, and v = cmax.
    - If delta == 0: h = 0, s = 0 (covers black); go to OUT.
    - Otherwise go to DIV_H.
  - DIV_H:
    - Pulse div_start in the first cycle, with dividend = |num| and divisor = delta.
    - Operands stay stable until div_complete.
    - On div_complete: frac = quotient with the numerator sign applied; go to DIV_S.
  - DIV_S:
    - Same handshake with dividend = delta and divisor = cmax.
    - On div_complete: s = quotient; go to MUL_H.
  - MUL_H:
    - Pulse mul_start, with mul_a = frac + (offset<<Q), signed add, and mul_b = 60<<Q.
    - On mul_complete: latch the result; go to WRAP.
  - WRAP, 1 cycle:
    - If the result is negative, h = result + (360<<Q).
    - Else if the result is ≥ 360<<Q, h = result - (360<<Q).
    - Else h = result.
    - Go to OUT.
  - OUT:
    - out_valid = 1; h, s, v, err are held stable while out_valid && !out_ready.
    - On out_ready: return to IDLE. in_ready rises the next cycle (no bypass).
- Error flag: err is set by any div_overflow or mul_overflow seen in the current pixel, and cleared on the next accept. The sequence continues regardless.
- Start pulses: exactly one div_start per division and one mul_start per pixel. A complete pulse arriving in an unexpected state is ignored.
- Width rules: all intermediate values are N bits; |frac| ≤ 1.0; mul_a range is [-1, 5], so h never exceeds 360<<Q.
- Latency: 2 cycles + 2×divider + multiplier + 1 + output stall. When delta == 0, latency is 2 cycles to out_valid.

Decomposition:
- Shared package:
  - state enum: IDLE, PREP, DIV_H, DIV_S, MUL_H, WRAP, OUT.
  - constants N and Q.
  - HUE_SCALE = 60<<Q and HUE_WRAP = 360<<Q.
  - hue branch offsets 0, 2, 4.
- Sub-module hsv_smag_addsub: combinational sign-magnitude add/subtract, reused for delta, the numerator, the offset add and the wrap.

Test Plan:
- Pure red (255,0,0):
  - h = 0x00000000, s = 0x00008000, v = 0x007F8000.
  - Exactly 2 div_start and 1 mul_start.
- Green (0,255,0) -> h = 0x003C0000 (120). Blue (0,0,255) -> h = 0x00780000 (240). s = 1.0 in both cases.
- Tie (255,255,0) -> R branch taken, h = 0x001E0000 (60). Magenta-ish (255,0,128) -> negative hue wrapped, h ≈ 329.88 (±1 LSB of the divider quotient).
- Gray (128,128,128) and black (0,0,0):
  - h = s = 0; v = 0x00400000 (gray) and 0 (black).
  - No div_start or mul_start pulse.
  - out_valid two cycles after accept.
- Back-pressure:
  - Hold out_ready = 0 for 10 cycles -> outputs stable, in_ready = 0, a new in_valid is not accepted.
  - Release -> the next pixel is accepted one cycle later.
- Fault and reset:
  - Assert rst during DIV_S -> all outputs 0, state IDLE, no further start pulses.
  - Inject div_overflow -> err = 1 with out_valid; err clears on the next accept.
